mul4_seq_ctrl: RTL



---
 rtl/mul4_pkg.sv | 14 +
 rtl/mul4_step.sv | 31 +++
 rtl/mul4_seq_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/mul4_pkg.sv
// Shared types and sizes for the sequential 4x4 multiplier.
package mul4_pkg;

    localparam int unsigned OPW   = 4;
    localparam int unsigned PRODW = 8;
    localparam int unsigned STEPS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/mul4_step.sv
// One shift-add iteration: gate A by P[0], add into the upper half, shift right with carry.
module mul4_step
    import mul4_pkg::OPW;
    import mul4_pkg::PRODW;
(
    input  logic [OPW-1:0]   a,
    input  logic [PRODW-1:0] p,
    output logic [PRODW-1:0] p_next
);

    logic [OPW-1:0] pp;
    logic [OPW-1:0] g;
    logic [OPW-1:0] pr;
    logic [OPW-1:0] s;
    logic           c1, c2, c3, c4;

    // MUL_unit: one partial-product row
    assign pp = a & {OPW{p[0]}};

    // fourbits_CLGadder with cin tied low
    assign g  = p[7:4] & pp;
    assign pr = p[7:4] ^ pp;
    assign c1 = g[0];
    assign c2 = g[1] | (pr[1] & g[0]);
    assign c3 = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0]);
    assign c4 = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1]) | (pr[3] & pr[2] & pr[1] & g[0]);
    assign s  = pr ^ {c3, c2, c1, 1'b0};

    assign p_next = {c4, s, p[3:1]};

endmodule

// File: rtl/mul4_seq_ctrl.sv
// Sequential 4x4 unsigned multiplier: one shared step datapath, valid/ready on both sides,
// tag carried through to the result.
module mul4_seq_ctrl
    import mul4_pkg::OPW;
    import mul4_pkg::PRODW;
    import mul4_pkg::state_t;
    import mul4_pkg::IDLE;
    import mul4_pkg::CALC;
    import mul4_pkg::DONE;
#(
    parameter int unsigned TAG_W = 2,
    parameter int unsigned STEPS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PRODW-1:0] out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    if (STEPS != mul4_pkg::STEPS) begin : g_steps_illegal
        $error("mul4_seq_ctrl: STEPS must equal the operand width");
    end

    state_t             state_q;
    logic [1:0]         cnt_q;
    logic [PRODW-1:0]   p_q;
    logic [PRODW-1:0]   p_next;
    logic [OPW-1:0]     a_q;
    logic [TAG_W-1:0]   tag_q;

    mul4_step u_step (
        .a      (a_q),
        .p      (p_q),
        .p_next (p_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            p_q       <= '0;
            a_q       <= '0;
            tag_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        p_q      <= {{(PRODW-OPW){1'b0}}, in_b};
                        tag_q    <= in_tag;
                        cnt_q    <= 2'd0;
                        state_q  <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    p_q   <= p_next;
                    cnt_q <= cnt_q + 2'd1;
                    // Full STEPS iterations regardless of operand values
                    if (cnt_q == 2'(STEPS - 1)) begin
                        state_q   <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_prod = p_q;
    assign out_tag  = tag_q;

endmodule
